bus_arbiter4: RTL and testbench

BUS_ARBITER4 -- requirements
Module: bus_arbiter4

---
 rtl/bus_arbiter4.sv | 183 ++++++++++++++++++
 tb/tb_bus_arbiter4.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter4
// Purpose  : Four-requester round-robin bus arbiter. One owner at a time. The
//            owner's data is registered onto dout, one beat per cycle, while
//            its request stays high. Every release passes through exactly one
//            IDLE cycle before the next grant. The search pointer advances
//            only when a grant ends.
// Ports    : clk        - single clock, rising edge
//            rst        - asynchronous active-high reset
//            req[3:0]   - request per requester (bit i = requester i)
//            di1..di4   - data of requesters 0..3 (N bits each)
//            gnt[3:0]   - registered one-hot grant, zero when no owner
//            sel[1:0]   - registered index of current/last owner
//            dout       - registered owner data (N bits)
//            dout_valid - registered, high when dout carries a new beat
// Options  : define ARB_TIMEOUT_EN to preempt an owner after MAX_BEATS beats
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter4 #(
  parameter int N         = 32,
  parameter int MAX_BEATS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [N-1:0] di1,
  input  logic [N-1:0] di2,
  input  logic [N-1:0] di3,
  input  logic [N-1:0] di4,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [N-1:0] dout,
  output logic         dout_valid
);

  if (MAX_BEATS < 1 || MAX_BEATS > 256) begin : g_max_beats_range
    $error("bus_arbiter4: MAX_BEATS must be in 1..256");
  end

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_busy = 1'b1;

  logic [0:0]   r_state;
  logic [0:0]   w_state_nxt;
  logic [3:0]   r_gnt;
  logic [3:0]   w_gnt_nxt;
  logic [1:0]   r_sel;
  logic [1:0]   w_sel_nxt;
  logic [1:0]   r_ptr;
  logic [1:0]   w_ptr_nxt;
  logic [N-1:0] r_dout;
  logic [N-1:0] w_dout_nxt;
  logic         r_dout_valid;
  logic         w_dout_valid_nxt;

  logic [1:0]   w_winner;
  logic         w_owner_req;
  logic [N-1:0] w_owner_di;
  logic         w_last_beat;

  // Round-robin search: walk offsets 3 down to 0 so the lowest offset from
  // ptr that has a request is the last (and therefore winning) assignment.
  always_comb begin
    w_winner = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[r_ptr + 2'(i)]) begin
        w_winner = r_ptr + 2'(i);
      end
    end
  end

  assign w_owner_req = req[r_sel];

  always_comb begin
    w_owner_di = di1;
    case (r_sel)
      2'd0:    w_owner_di = di1;
      2'd1:    w_owner_di = di2;
      2'd2:    w_owner_di = di3;
      default: w_owner_di = di4;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  // Counts beats of the current grant; cleared while idle so every new
  // grant starts from zero.
  localparam logic [7:0] c_last_beat = 8'(MAX_BEATS - 1);
  logic [7:0] r_beat_cnt;

  assign w_last_beat = (r_beat_cnt == c_last_beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (r_state == c_idle) begin
      r_beat_cnt <= '0;
    end else if (w_owner_req && !w_last_beat) begin
      r_beat_cnt <= r_beat_cnt + 8'd1;
    end
  end
`else
  assign w_last_beat = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (|req) begin
          w_state_nxt = c_busy;
        end
      end
      default: begin
        if (!w_owner_req || w_last_beat) begin
          w_state_nxt = c_idle;
        end
      end
    endcase
  end

  // Output logic: next values of the registered outputs and the pointer.
  // On a preempting beat the final beat is still delivered.
  always_comb begin
    w_gnt_nxt        = r_gnt;
    w_sel_nxt        = r_sel;
    w_ptr_nxt        = r_ptr;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = 1'b0;
    case (r_state)
      c_idle: begin
        w_gnt_nxt = 4'b0000;
        if (|req) begin
          w_gnt_nxt = 4'b0001 << w_winner;
          w_sel_nxt = w_winner;
        end
      end
      default: begin
        if (w_owner_req) begin
          w_dout_nxt       = w_owner_di;
          w_dout_valid_nxt = 1'b1;
        end
        if (!w_owner_req || w_last_beat) begin
          w_gnt_nxt = 4'b0000;
          w_ptr_nxt = r_sel + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt        <= 4'b0000;
      r_sel        <= 2'd0;
      r_ptr        <= 2'd0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_gnt        <= w_gnt_nxt;
      r_sel        <= w_sel_nxt;
      r_ptr        <= w_ptr_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
    end
  end

  assign gnt        = r_gnt;
  assign sel        = r_sel;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter4
// Purpose  : Self-checking bench for bus_arbiter4. Directed stimulus queues
//            the expected grants and data beats; a negedge monitor pops and
//            compares whenever the arbiter presents a new grant or a beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter4;

  localparam int N = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int MB = 4;
`else
  localparam int MB = 8;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [N-1:0] di1, di2, di3, di4;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [N-1:0] dout;
  logic         dout_valid;

  int n_chk  = 0;
  int n_fail = 0;

  logic [N-1:0] exp_data[$];
  logic [3:0]   exp_gnt[$];
  logic [3:0]   prev_gnt = 4'b0000;
  logic [N-1:0] mon_data;
  logic [3:0]   mon_gnt;

  bus_arbiter4 #(.N(N), .MAX_BEATS(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .di1        (di1),
    .di2        (di2),
    .di3        (di3),
    .di4        (di4),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] onehot_idx(input logic [3:0] g);
    case (g)
      4'b0001: return 3'd0;
      4'b0010: return 3'd1;
      4'b0100: return 3'd2;
      4'b1000: return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  // Monitor: consumes expected beats/grants as the DUT presents them.
  always @(negedge clk) begin
    if (rst) begin
      prev_gnt = 4'b0000;
    end else begin
      if (dout_valid) begin
        if (exp_data.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got dout=%h, required no beat (t=%0t)", dout, $time);
        end else begin
          mon_data = exp_data.pop_front();
          chk("dout_beat", dout, mon_data);
        end
      end
      if (gnt != 4'b0000 && gnt != prev_gnt) begin
        if (exp_gnt.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_grant: got gnt=%b, required none (t=%0t)", gnt, $time);
        end else begin
          mon_gnt = exp_gnt.pop_front();
          chk("grant_order", {28'd0, gnt}, {28'd0, mon_gnt});
        end
      end
      if (gnt != 4'b0000) begin
        chk("sel_matches_gnt", {30'd0, sel}, {29'd0, onehot_idx(gnt)});
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    req = 4'b0000;
    di1 = '0; di2 = '0; di3 = '0; di4 = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset_gnt", gnt, 0);
    chk("reset_sel", sel, 0);
    chk("reset_dout", dout, 0);
    chk("reset_valid", dout_valid, 0);
    step(2);
    rst = 1'b0;

    // Single requester 2, three beats, then release (ptr -> 3)
    di3 = 32'hCAFE0003;
    req = 4'b0100;
    exp_gnt.push_back(4'b0100);
    repeat (3) exp_data.push_back(32'hCAFE0003);
    step(1);
    chk("t1_gnt", gnt, 32'h4);
    chk("t1_sel", sel, 2);
    step(3);
    req = 4'b0000;
    step(1);
    chk("t1_release_gnt", gnt, 0);
    chk("t1_valid_low", dout_valid, 0);
    chk("t1_dout_hold", dout, 32'hCAFE0003);

    // ptr=3: search 3,0 picks requester 0; requester 2 waits for IDLE
    req = 4'b0101;
    exp_gnt.push_back(4'b0001);
    step(1);
    chk("t2_wrap_gnt", gnt, 32'h1);
    di1 = 32'h11110000; exp_data.push_back(32'h11110000); step(1);
    di1 = 32'h11110001; exp_data.push_back(32'h11110001); step(1);
    chk("t2_owner_kept", gnt, 32'h1);
    req = 4'b0100;
    step(1);
    chk("t2_idle_gap", gnt, 0);
    exp_gnt.push_back(4'b0100);
    step(1);
    chk("t2_next_gnt", gnt, 32'h4);
    di3 = 32'h33330001; exp_data.push_back(32'h33330001); step(1);
    req = 4'b0000;
    step(1);
    chk("t2_release", gnt, 0);

    // ptr=3: owner 1, then 0 and 3 rise; after release ptr=2 -> 3, then 0
    req = 4'b0010;
    exp_gnt.push_back(4'b0010);
    step(1);
    di2 = 32'h22220001; exp_data.push_back(32'h22220001); step(1);
    req = 4'b1011;
    di2 = 32'h22220002; exp_data.push_back(32'h22220002); step(1);
    chk("t3_owner_kept", gnt, 32'h2);
    req = 4'b1001;
    step(1);
    chk("t3_release", gnt, 0);
    exp_gnt.push_back(4'b1000);
    step(1);
    chk("t3_gnt3", gnt, 32'h8);
    chk("t3_sel3", sel, 3);
    di4 = 32'h44440001; exp_data.push_back(32'h44440001); step(1);
    req = 4'b0001;
    step(1);
    chk("t3_release3", gnt, 0);
    exp_gnt.push_back(4'b0001);
    step(1);
    chk("t3_gnt0", gnt, 32'h1);
    di1 = 32'h11110002; exp_data.push_back(32'h11110002); step(1);
    req = 4'b0000;
    step(1);

    // One-cycle pulse on requester 1: grant then release, no beat
    req = 4'b0010;
    exp_gnt.push_back(4'b0010);
    step(1);
    chk("t4_pulse_gnt", gnt, 32'h2);
    req = 4'b0000;
    step(1);
    chk("t4_pulse_release", gnt, 0);
    chk("t4_no_beat", dout_valid, 0);
    chk("t4_dout_hold", dout, 32'h11110002);

`ifndef ARB_TIMEOUT_EN
    // ptr=2: long grant to requester 2 with requester 0 waiting
    req = 4'b0101;
    exp_gnt.push_back(4'b0100);
    step(1);
    for (int i = 0; i < 300; i++) begin
      di3 = 32'hD0000000 + i;
      exp_data.push_back(32'hD0000000 + i);
      step(1);
      chk("t5_hold_gnt", gnt, 32'h4);
    end
    req = 4'b0001;
    step(1);
    chk("t5_release", gnt, 0);
    exp_gnt.push_back(4'b0001);
    step(1);
    chk("t5_gnt0", gnt, 32'h1);
    di1 = 32'h11110003; exp_data.push_back(32'h11110003); step(1);
    req = 4'b0000;
    step(1);
`endif

    // Reset mid-grant aborts; arbitration restarts from ptr=0
    req = 4'b0100;
    exp_gnt.push_back(4'b0100);
    step(1);
    di3 = 32'h5555AAAA; exp_data.push_back(32'h5555AAAA); step(1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_gnt", gnt, 0);
    chk("t6_rst_sel", sel, 0);
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_valid", dout_valid, 0);
    req = 4'b0011;
    step(1);
    rst = 1'b0;
    exp_gnt.push_back(4'b0001);
    step(1);
    chk("t6_restart_gnt", gnt, 32'h1);
    di1 = 32'h11110004; exp_data.push_back(32'h11110004); step(1);
    req = 4'b0000;
    step(1);

`ifdef ARB_TIMEOUT_EN
    // All four requesting: strict rotation, MB beats each, one IDLE gap
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    di1 = 32'hA0000000; di2 = 32'hA0000001;
    di3 = 32'hA0000002; di4 = 32'hA0000003;
    for (int g = 0; g < 5; g++) begin
      exp_gnt.push_back(4'(4'b0001 << (g % 4)));
      repeat (MB) exp_data.push_back(32'hA0000000 + (g % 4));
    end
    req = 4'b1111;
    for (int k = 1; k <= 5 * (MB + 1); k++) begin
      step(1);
      if (k % (MB + 1) == 0) chk("t7_idle_gap", gnt, 0);
      else chk("t7_owner", gnt, 32'(1) << (((k - 1) / (MB + 1)) % 4));
    end
    req = 4'b0000;
    step(2);
`endif

    step(3);
    chk("data_queue_drained", exp_data.size(), 0);
    chk("gnt_queue_drained", exp_gnt.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
